// File: rtl/sbox_sweep_checker_if.sv
// Handshake/result bundle between the sweep checker and its harness.
// slave  : the checker itself (drives the S-box input side and the results).
// master : the harness/S-box side (drives start, the S-box output, readback address).
interface sbox_sweep_checker_if #(
  parameter int N = 6
);
  logic         start;
  logic [N-1:0] x_out;
  logic         x_valid;
  logic [N-1:0] y_in;
  logic         busy;
  logic         done;
  logic         is_perm;
  logic [N:0]   collisions;
  logic [N:0]   fixed_pts;
  logic [N-1:0] rd_addr;
  logic [N-1:0] rd_data;

  modport slave (
    input  start, y_in, rd_addr,
    output x_out, x_valid, busy, done, is_perm, collisions, fixed_pts, rd_data
  );

  modport master (
    output start, y_in, rd_addr,
    input  x_out, x_valid, busy, done, is_perm, collisions, fixed_pts, rd_data
  );
endinterface

// File: rtl/sbox_sweep_checker.sv
// S-box sweep checker: issues x = 0..2^N-1 to a wrapped S-box, captures the
// outputs SBOX_LAT cycles later and reports bijectivity, collision count and
// fixed-point count.
// Optional feature macro: SWEEP_READBACK_EN (captured table with registered
// readback through rd_addr/rd_data). Undefined: rd_data is tied to 0.
module sbox_sweep_checker #(
  parameter int N        = 6,
  parameter int SBOX_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  sbox_sweep_checker_if.slave   bus
);

  localparam int unsigned DEPTH   = 1 << N;
  localparam logic [N:0]  CNT_MAX = (N+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     x_out_q, x_out_d;
  logic [DEPTH-1:0] seen_q, seen_d;
  logic [N:0]       coll_q, coll_d;
  logic [N:0]       fix_q, fix_d;
  logic             perm_q, perm_d;

  logic             x_valid;
  logic             cap_v;
  logic [N-1:0]     cap_idx;
  logic             last_cap;

  assign x_valid = (state_q == S_ISSUE);

  // Capture pipeline: (valid, index) travel alongside the S-box so each
  // y_in is paired with the x that produced it.
  generate
    if (SBOX_LAT == 0) begin : g_comb
      assign cap_v   = x_valid;
      assign cap_idx = x_out_q;
    end else begin : g_pipe
      localparam int unsigned LAT = SBOX_LAT;
      logic [LAT-1:0] v_q;
      logic [N-1:0]   idx_q [LAT];

      // Valid bits are reset so an aborted sweep leaves no stale captures.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= '0;
        end else begin
          v_q[0] <= x_valid;
          for (int unsigned i = 1; i < LAT; i++) v_q[i] <= v_q[i-1];
        end
      end

      // Index stages carry no reset; they are qualified by v_q.
      always_ff @(posedge clk) begin
        idx_q[0] <= x_out_q;
        for (int unsigned i = 1; i < LAT; i++) idx_q[i] <= idx_q[i-1];
      end

      assign cap_v   = v_q[LAT-1];
      assign cap_idx = idx_q[LAT-1];
    end
  endgenerate

  assign last_cap = cap_v && (cap_idx == '1);

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_out_q <= '0;
      seen_q  <= '0;
      coll_q  <= '0;
      fix_q   <= '0;
      perm_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_out_q <= x_out_d;
      seen_q  <= seen_d;
      coll_q  <= coll_d;
      fix_q   <= fix_d;
      perm_q  <= perm_d;
    end
  end

  // Next-state, issue counter and capture bookkeeping.
  always_comb begin
    state_d = state_q;
    x_out_d = x_out_q;
    seen_d  = seen_q;
    coll_d  = coll_q;
    fix_d   = fix_q;
    perm_d  = perm_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ISSUE;
          x_out_d = '0;
          seen_d  = '0;
          coll_d  = '0;
          fix_d   = '0;
          perm_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        if (x_out_q == '1) begin
          // With a combinational S-box the last capture is this very cycle.
          state_d = (SBOX_LAT == 0) ? S_DONE : S_DRAIN;
        end else begin
          x_out_d = x_out_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (last_cap) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cap_v) begin
      if (seen_q[bus.y_in]) begin
        if (coll_q != CNT_MAX) coll_d = coll_q + 1'b1;
      end else begin
        seen_d[bus.y_in] = 1'b1;
      end
      if (bus.y_in == cap_idx) begin
        if (fix_q != CNT_MAX) fix_d = fix_q + 1'b1;
      end
    end

    // is_perm must reflect the final capture, hence coll_d rather than coll_q.
    if ((state_d == S_DONE) && (state_q != S_DONE)) perm_d = (coll_d == '0);
  end

  assign bus.x_out      = x_out_q;
  assign bus.x_valid    = x_valid;
  assign bus.busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.is_perm    = perm_q;
  assign bus.collisions = coll_q;
  assign bus.fixed_pts  = fix_q;

`ifdef SWEEP_READBACK_EN
  logic [N-1:0] tab_q [DEPTH];
  logic [N-1:0] rd_data_q;

  // Captured table; intentionally not reset, only meaningful after a sweep.
  always_ff @(posedge clk) begin
    if (cap_v) tab_q[cap_idx] <= bus.y_in;
  end

  // Registered readback, available in every state.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= tab_q[bus.rd_addr];
  end

  assign bus.rd_data = rd_data_q;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^bus.rd_addr;
  assign bus.rd_data    = '0;
`endif

endmodule

// File: tb/tb_sbox_sweep_checker.sv
// Bench for sbox_sweep_checker: a combinational (SBOX_LAT=0) and a two-stage
// (SBOX_LAT=2) instance are swept side by side over the same S-box table;
// expected results come from counting the table's output histogram.
module tb_sbox_sweep_checker;
  localparam int N     = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sbox_sweep_checker_if #(.N(N)) if0 ();
  sbox_sweep_checker_if #(.N(N)) if2 ();

  sbox_sweep_checker #(.N(N), .SBOX_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  sbox_sweep_checker #(.N(N), .SBOX_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // Behavioural S-boxes: same table, combinational and registered twice.
  logic [N-1:0] sbox [DEPTH];
  logic [N-1:0] p1, p2;
  assign if0.y_in = sbox[if0.x_out];
  always @(posedge clk) begin
    p1 <= sbox[if2.x_out];
    p2 <= p1;
  end
  assign if2.y_in = p2;

  int n_vec = 0;
  int n_err = 0;
  int exp_coll, exp_fix;
  logic exp_perm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if0.start = v;
    if2.start = v;
  endtask

  // Reference: collisions = captures minus distinct outputs; fixed = #{x : f(x)==x}.
  task automatic model();
    int cnt [DEPTH];
    for (int v = 0; v < DEPTH; v++) cnt[v] = 0;
    exp_fix = 0;
    for (int x = 0; x < DEPTH; x++) begin
      cnt[sbox[x]]++;
      if (int'(sbox[x]) == x) exp_fix++;
    end
    exp_coll = 0;
    for (int v = 0; v < DEPTH; v++) if (cnt[v] > 1) exp_coll += cnt[v] - 1;
    exp_perm = (exp_coll == 0);
  endtask

  // mode 0 identity, 1 xor k, 2 constant k, 3 random permutation, 4 random map
  task automatic load(input int mode, input logic [N-1:0] k);
    logic [N-1:0] t;
    int j;
    for (int x = 0; x < DEPTH; x++) begin
      case (mode)
        0:       sbox[x] = N'(x);
        1:       sbox[x] = N'(x) ^ k;
        2:       sbox[x] = k;
        3:       sbox[x] = N'(x);
        default: sbox[x] = N'($urandom_range(DEPTH-1, 0));
      endcase
    end
    if (mode == 3) begin
      for (int i = DEPTH-1; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        t = sbox[i]; sbox[i] = sbox[j]; sbox[j] = t;
      end
    end
    model();
  endtask

  // Full sweep; start is sampled in cycle 0, the loop body runs in cycle c.
  task automatic sweep();
    set_start(1'b1);
    step();
    for (int c = 1; c <= 72; c++) begin
      // start during busy (10) and in dut0's DONE cycle (65) must be ignored
      set_start(c == 10 || c == 65);
      chk("x_out0",   32'(if0.x_out),   (c <= 64) ? c - 1 : 63);
      chk("x_out2",   32'(if2.x_out),   (c <= 64) ? c - 1 : 63);
      chk("x_valid0", 32'(if0.x_valid), 32'(c <= 64));
      chk("x_valid2", 32'(if2.x_valid), 32'(c <= 64));
      chk("busy0",    32'(if0.busy),    32'(c <= 64));
      chk("busy2",    32'(if2.busy),    32'(c <= 66));
      chk("done0",    32'(if0.done),    32'(c == 65));
      chk("done2",    32'(if2.done),    32'(c == 67));
      chk("is_perm0", 32'(if0.is_perm), (c >= 65) ? 32'(exp_perm) : 0);
      chk("is_perm2", 32'(if2.is_perm), (c >= 67) ? 32'(exp_perm) : 0);
      if (c == 1) begin
        chk("coll_clr0", 32'(if0.collisions), 0);
        chk("coll_clr2", 32'(if2.collisions), 0);
        chk("fix_clr0",  32'(if0.fixed_pts),  0);
        chk("fix_clr2",  32'(if2.fixed_pts),  0);
      end
      if (c >= 65) begin
        chk("coll0", 32'(if0.collisions), exp_coll);
        chk("fix0",  32'(if0.fixed_pts),  exp_fix);
      end
      if (c >= 67) begin
        chk("coll2", 32'(if2.collisions), exp_coll);
        chk("fix2",  32'(if2.fixed_pts),  exp_fix);
      end
      step();
    end
    set_start(1'b0);
  endtask

  task automatic readback(input logic [N-1:0] a);
    logic [N-1:0] e;
`ifdef SWEEP_READBACK_EN
    e = sbox[a];
`else
    e = '0;
`endif
    if0.rd_addr = a;
    if2.rd_addr = a;
    step();
    chk("rd_data0", 32'(if0.rd_data), 32'(e));
    chk("rd_data2", 32'(if2.rd_data), 32'(e));
  endtask

  task automatic chk_reset_vals();
    chk("rst_x_out0",   32'(if0.x_out),      0);
    chk("rst_x_out2",   32'(if2.x_out),      0);
    chk("rst_x_valid0", 32'(if0.x_valid),    0);
    chk("rst_x_valid2", 32'(if2.x_valid),    0);
    chk("rst_busy0",    32'(if0.busy),       0);
    chk("rst_busy2",    32'(if2.busy),       0);
    chk("rst_done0",    32'(if0.done),       0);
    chk("rst_done2",    32'(if2.done),       0);
    chk("rst_perm0",    32'(if0.is_perm),    0);
    chk("rst_perm2",    32'(if2.is_perm),    0);
    chk("rst_coll0",    32'(if0.collisions), 0);
    chk("rst_coll2",    32'(if2.collisions), 0);
    chk("rst_fix0",     32'(if0.fixed_pts),  0);
    chk("rst_fix2",     32'(if2.fixed_pts),  0);
    chk("rst_rd0",      32'(if0.rd_data),    0);
    chk("rst_rd2",      32'(if2.rd_data),    0);
  endtask

  initial begin
    logic [N-1:0] k;
    rst = 1'b1;
    set_start(1'b0);
    if0.rd_addr = '0;
    if2.rd_addr = '0;
    load(0, '0);
    step(); step(); step();
    chk_reset_vals();
    rst = 1'b0;
    step();

    // identity: permutation, every x a fixed point
    load(0, '0);
    sweep();

    // xor 0x2A: permutation without fixed points; readback of address 5
    load(1, 6'h2A);
    sweep();
    readback(6'h05);

    // all-zero output: 63 collisions, one fixed point
    load(2, '0);
    sweep();

    // reset mid-sweep, constant S-box so counters are nonzero before the abort
    k = N'($urandom_range(DEPTH-1, 0));
    load(2, k);
    set_start(1'b1);
    step();
    set_start(1'b0);
    for (int c = 1; c < 30; c++) step();
    chk("coll_mid0", 32'(if0.collisions), 28);
    chk("coll_mid2", 32'(if2.collisions), 26);
    rst = 1'b1;
    step();
    chk_reset_vals();
    rst = 1'b0;

    // randomized tables after the abort
    load(3, '0);
    sweep();
    load(4, '0);
    sweep();
    for (int i = 0; i < 4; i++) readback(N'($urandom_range(DEPTH-1, 0)));
    k = N'($urandom_range(DEPTH-1, 0));
    load(1, k);
    sweep();
    load(4, '0);
    sweep();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
